// File: rtl/perf_retire_feeder_pkg.sv
// Shared integer-unit types used by the performance-counter feeder.
//   NTHREADIDMSB            : MSB index of a thread ID (8 hardware threads)
//   iu_clk_type             : integer-unit clock bundle; only .clk is carried
//   perf_count_write_req_in : one counter-update request {valid, tid, inst}
package perf_retire_feeder_pkg;

   localparam int NTHREADIDMSB = 2;

   typedef struct packed {
      logic clk;
   } iu_clk_type;

   typedef struct packed {
      logic                  valid;
      logic [NTHREADIDMSB:0] tid;
      logic [31:0]           inst;
   } perf_count_write_req_in;

endpackage

// File: rtl/perf_retire_feeder.sv
// Upstream feeder for the per-thread performance counters.
// Taps the commit stream. It drops annulled/trapped commits and commits from
// threads whose enable bit is clear, and buffers the rest in a small FIFO.
// It issues at most one counter request per cycle, and never the same thread
// on two consecutive cycles, so the counter RAM read-modify-write cannot
// collide. Commits that find the FIFO full are counted in drop_cnt.
//
// Parameters:
//   FIFO_DEPTH : FIFO entries (power of two, >= 2)
//   DROP_W     : drop counter width
// Ports:
//   gclk         in  : clock bundle (gclk.clk only)
//   rst          in  : asynchronous active-low reset
//   commit_valid in  : an instruction commits this cycle
//   commit_tid   in  : thread ID of the commit
//   commit_inst  in  : instruction word of the commit
//   commit_annul in  : commit annulled/trapped, not counted
//   cfg_we       in  : load the thread-enable mask
//   cfg_mask     in  : per-thread count enable, bit i = thread i
//   drop_clr     in  : clear drop_cnt
//   wreq_out     out : registered counter request {valid, tid, inst}
//   drop_cnt     out : saturating count of commits lost to overflow
//   fifo_level   out : current FIFO occupancy
module perf_retire_feeder
   import perf_retire_feeder_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DROP_W     = 16
) (
   input  iu_clk_type                       gclk,
   input  logic                             rst,
   input  logic                             commit_valid,
   input  logic [NTHREADIDMSB:0]            commit_tid,
   input  logic [31:0]                      commit_inst,
   input  logic                             commit_annul,
   input  logic                             cfg_we,
   input  logic [2**(NTHREADIDMSB+1)-1:0]   cfg_mask,
   input  logic                             drop_clr,
   output perf_count_write_req_in           wreq_out,
   output logic [DROP_W-1:0]                drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int TW   = NTHREADIDMSB + 1;
   localparam int NTHR = 2**TW;

   localparam logic [AW:0]       PTR_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]       LVL_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};
   localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

   typedef struct packed {
      logic [TW-1:0] tid;
      logic [31:0]   inst;
   } entry_t;

   logic                   clk_s;
   entry_t                 mem_r [FIFO_DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]            wr_ptr_r;
   logic [AW:0]            rd_ptr_r;
   logic [NTHR-1:0]        mask_r;
   perf_count_write_req_in wreq_r;
   logic [DROP_W-1:0]      drop_r;
   logic [AW:0]            level_r;

   logic [AW-1:0]          wr_idx_s;
   logic [AW-1:0]          rd_idx_s;
   entry_t                 head_s;
   logic                   empty_s;
   logic                   full_s;
   logic                   acc_s;
   logic                   pop_s;
   logic                   push_s;
   logic                   drop_s;
   logic [AW:0]            level_nxt_s;
   logic [DROP_W-1:0]      drop_nxt_s;
   perf_count_write_req_in wreq_nxt_s;

   assign clk_s = gclk.clk;

   // FIFO status, issue eligibility and push/drop decision for this edge.
   always_comb begin
      wr_idx_s = wr_ptr_r[AW-1:0];
      rd_idx_s = rd_ptr_r[AW-1:0];
      head_s   = mem_r[rd_idx_s];
      empty_s  = (wr_ptr_r == rd_ptr_r);
      full_s   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_idx_s == rd_idx_s);
      // The head is blocked only when it repeats the thread issued last cycle;
      // it is never skipped, so one blocked head stalls the whole FIFO.
      pop_s    = ~empty_s & ~(wreq_r.valid & (head_s.tid == wreq_r.tid));
      acc_s    = commit_valid & ~commit_annul & mask_r[commit_tid];
      // A full FIFO still takes the commit when the head leaves on this edge.
      push_s   = acc_s & (~full_s | pop_s);
      drop_s   = acc_s & full_s & ~pop_s;
   end

   // Occupancy follows push/pop; both together leave it unchanged.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase
   end

   // Drop counter: clear wins over hold, but a drop on the clearing edge counts.
   always_comb begin
      drop_nxt_s = drop_r;
      if (drop_clr) begin
         drop_nxt_s = drop_s ? DROP_ONE : {DROP_W{1'b0}};
      end else if (drop_s && (drop_r != DROP_MAX)) begin
         drop_nxt_s = drop_r + DROP_ONE;
      end else begin
         drop_nxt_s = drop_r;
      end
   end

   // Request register: load the head on a pop, else only clear valid.
   always_comb begin
      wreq_nxt_s = wreq_r;
      if (pop_s) begin
         wreq_nxt_s.valid = 1'b1;
         wreq_nxt_s.tid   = head_s.tid;
         wreq_nxt_s.inst  = head_s.inst;
      end else begin
         wreq_nxt_s.valid = 1'b0;
      end
   end

   // Control state: pointers, level, mask, drop counter and request register.
   always_ff @(posedge clk_s or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         level_r  <= {(AW+1){1'b0}};
         mask_r   <= {NTHR{1'b1}};
         drop_r   <= {DROP_W{1'b0}};
         wreq_r   <= {1'b0, {TW{1'b0}}, 32'h0000_0000};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         if (cfg_we) begin
            mask_r <= cfg_mask;
         end else begin
            mask_r <= mask_r;
         end
         level_r <= level_nxt_s;
         drop_r  <= drop_nxt_s;
         wreq_r  <= wreq_nxt_s;
      end
   end

   // FIFO storage; cleared on reset so no stale entry can ever surface.
   always_ff @(posedge clk_s or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_r[i] <= {{TW{1'b0}}, 32'h0000_0000};
         end
      end else begin
         if (push_s) begin
            mem_r[wr_idx_s] <= {commit_tid, commit_inst};
         end
      end
   end

   assign wreq_out   = wreq_r;
   assign drop_cnt   = drop_r;
   assign fifo_level = level_r;

endmodule

// File: tb/tb_perf_retire_feeder.sv
// Directed self-checking bench for perf_retire_feeder (FIFO_DEPTH = 4).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
module tb_perf_retire_feeder;
   import perf_retire_feeder_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   iu_clk_type             gclk;
   logic                   commit_valid = 1'b0;
   logic [2:0]             commit_tid   = 3'd0;
   logic [31:0]            commit_inst  = 32'h0000_0000;
   logic                   commit_annul = 1'b0;
   logic                   cfg_we       = 1'b0;
   logic [7:0]             cfg_mask     = 8'h00;
   logic                   drop_clr     = 1'b0;
   perf_count_write_req_in wreq_out;
   logic [15:0]            drop_cnt;
   logic [2:0]             fifo_level;

   int n_cmp = 0;
   int n_mis = 0;

   assign gclk.clk = clk;
   always #5 clk = ~clk;

   perf_retire_feeder #(.FIFO_DEPTH(4), .DROP_W(16)) dut (
      .gclk         (gclk),
      .rst          (rst),
      .commit_valid (commit_valid),
      .commit_tid   (commit_tid),
      .commit_inst  (commit_inst),
      .commit_annul (commit_annul),
      .cfg_we       (cfg_we),
      .cfg_mask     (cfg_mask),
      .drop_clr     (drop_clr),
      .wreq_out     (wreq_out),
      .drop_cnt     (drop_cnt),
      .fifo_level   (fifo_level)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
      end
   endtask

   // Apply one commit (or idle) for one edge, then return 1 unit after it.
   task automatic drive(input logic v, input logic [2:0] t, input logic [31:0] i, input logic a);
      commit_valid = v;
      commit_tid   = t;
      commit_inst  = i;
      commit_annul = a;
      @(posedge clk);
      #1;
      commit_valid = 1'b0;
      commit_annul = 1'b0;
      cfg_we       = 1'b0;
      drop_clr     = 1'b0;
   endtask

   task automatic idle();
      drive(1'b0, 3'd0, 32'h0000_0000, 1'b0);
   endtask

   task automatic exp_req(input string tag, input logic v, input logic [2:0] t, input logic [31:0] i);
      chk({tag, ".valid"}, 64'(wreq_out.valid), 64'(v));
      if (v) begin
         chk({tag, ".tid"},  64'(wreq_out.tid),  64'(t));
         chk({tag, ".inst"}, 64'(wreq_out.inst), 64'(i));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int adj;
      logic prev_v;

      // Reset state
      #1 rst = 1'b0;
      #1;
      chk("rst.valid", 64'(wreq_out.valid), 64'd0);
      chk("rst.tid",   64'(wreq_out.tid),   64'd0);
      chk("rst.inst",  64'(wreq_out.inst),  64'd0);
      chk("rst.level", 64'(fifo_level),     64'd0);
      chk("rst.drop",  64'(drop_cnt),       64'd0);
      idle();
      idle();
      rst = 1'b1;

      // Test 1: tids 0..3 back to back, 2-cycle latency, one per cycle
      drive(1'b1, 3'd0, 32'h1000_0000, 1'b0);
      exp_req("t1.e1", 1'b0, 3'd0, 32'h0);
      chk("t1.e1.level", 64'(fifo_level), 64'd1);
      drive(1'b1, 3'd1, 32'h1000_0001, 1'b0);
      exp_req("t1.e2", 1'b1, 3'd0, 32'h1000_0000);
      drive(1'b1, 3'd2, 32'h1000_0002, 1'b0);
      exp_req("t1.e3", 1'b1, 3'd1, 32'h1000_0001);
      drive(1'b1, 3'd3, 32'h1000_0003, 1'b0);
      exp_req("t1.e4", 1'b1, 3'd2, 32'h1000_0002);
      idle();
      exp_req("t1.e5", 1'b1, 3'd3, 32'h1000_0003);
      chk("t1.e5.level", 64'(fifo_level), 64'd0);
      idle();
      exp_req("t1.e6", 1'b0, 3'd0, 32'h0);
      chk("t1.drop", 64'(drop_cnt), 64'd0);

      // Test 2: tid 5 twice -> request, bubble, request
      drive(1'b1, 3'd5, 32'h2000_0000, 1'b0);
      exp_req("t2.e1", 1'b0, 3'd0, 32'h0);
      chk("t2.e1.level", 64'(fifo_level), 64'd1);
      drive(1'b1, 3'd5, 32'h2000_0001, 1'b0);
      exp_req("t2.e2", 1'b1, 3'd5, 32'h2000_0000);
      chk("t2.e2.level", 64'(fifo_level), 64'd1);
      idle();
      exp_req("t2.e3", 1'b0, 3'd0, 32'h0);
      chk("t2.e3.level", 64'(fifo_level), 64'd1);
      idle();
      exp_req("t2.e4", 1'b1, 3'd5, 32'h2000_0001);
      chk("t2.e4.level", 64'(fifo_level), 64'd0);
      idle();
      exp_req("t2.e5", 1'b0, 3'd0, 32'h0);

      // Test 3: tid 2 every cycle for 20 cycles, then drain
      adj = 0;
      prev_v = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1, 3'd2, 32'h3000_0000 + 32'(k), 1'b0);
         chk($sformatf("t3.e%0d.valid", k), 64'(wreq_out.valid), 64'((k % 2) == 0));
         chk($sformatf("t3.e%0d.level", k), 64'(fifo_level), 64'((k <= 8) ? (k + 1) / 2 : 4));
         if (prev_v && wreq_out.valid) adj++;
         prev_v = wreq_out.valid;
      end
      chk("t3.drop", 64'(drop_cnt), 64'd6);
      for (int k = 21; k <= 28; k++) begin
         idle();
         chk($sformatf("t3.e%0d.valid", k), 64'(wreq_out.valid), 64'((k % 2) == 0));
         chk($sformatf("t3.e%0d.level", k), 64'(fifo_level), 64'((k <= 21) ? 4 : 4 - (k - 20) / 2));
         if (prev_v && wreq_out.valid) adj++;
         prev_v = wreq_out.valid;
      end
      chk("t3.adjacent", 64'(adj), 64'd0);
      drop_clr = 1'b1;
      idle();
      chk("t3.clr", 64'(drop_cnt), 64'd0);

      // Test 4: only thread 1 enabled; annulled commit not counted
      cfg_we   = 1'b1;
      cfg_mask = 8'h02;
      idle();
      drive(1'b1, 3'd0, 32'h4000_0000, 1'b0);
      exp_req("t4.e1", 1'b0, 3'd0, 32'h0);
      chk("t4.e1.level", 64'(fifo_level), 64'd0);
      drive(1'b1, 3'd1, 32'h4000_0001, 1'b0);
      chk("t4.e2.level", 64'(fifo_level), 64'd1);
      drive(1'b1, 3'd2, 32'h4000_0002, 1'b0);
      exp_req("t4.e3", 1'b1, 3'd1, 32'h4000_0001);
      chk("t4.e3.level", 64'(fifo_level), 64'd0);
      idle();
      exp_req("t4.e4", 1'b0, 3'd0, 32'h0);
      drive(1'b1, 3'd1, 32'h4000_0003, 1'b1);
      chk("t4.annul.level", 64'(fifo_level), 64'd0);
      idle();
      exp_req("t4.annul", 1'b0, 3'd0, 32'h0);

      // Test 5: full FIFO with eligible head takes a commit; clear+drop -> 1
      cfg_we   = 1'b1;
      cfg_mask = 8'h14;
      idle();
      for (int k = 1; k <= 7; k++) begin
         drive(1'b1, 3'd2, 32'h5000_0000 + 32'(k), 1'b0);
      end
      chk("t5.full.level", 64'(fifo_level), 64'd4);
      chk("t5.full.valid", 64'(wreq_out.valid), 64'd0);
      drive(1'b1, 3'd4, 32'h6000_0000, 1'b0);
      exp_req("t5.e8", 1'b1, 3'd2, 32'h5000_0004);
      chk("t5.e8.level", 64'(fifo_level), 64'd4);
      chk("t5.e8.drop",  64'(drop_cnt),   64'd0);
      drop_clr = 1'b1;
      drive(1'b1, 3'd4, 32'h6000_0001, 1'b0);
      exp_req("t5.e9", 1'b0, 3'd0, 32'h0);
      chk("t5.e9.drop",  64'(drop_cnt),   64'd1);
      chk("t5.e9.level", 64'(fifo_level), 64'd4);
      idle();
      exp_req("t5.e10", 1'b1, 3'd2, 32'h5000_0005);
      chk("t5.e10.level", 64'(fifo_level), 64'd3);

      // Test 6: asynchronous reset with 3 entries buffered
      #2 rst = 1'b0;
      #1;
      chk("t6.async.valid", 64'(wreq_out.valid), 64'd0);
      chk("t6.async.level", 64'(fifo_level),     64'd0);
      chk("t6.async.drop",  64'(drop_cnt),       64'd0);
      idle();
      chk("t6.held.level", 64'(fifo_level), 64'd0);
      rst = 1'b1;
      drive(1'b1, 3'd6, 32'h7000_0000, 1'b0);
      exp_req("t6.r1", 1'b0, 3'd0, 32'h0);
      chk("t6.r1.level", 64'(fifo_level), 64'd1);
      idle();
      exp_req("t6.r2", 1'b1, 3'd6, 32'h7000_0000);
      chk("t6.r2.level", 64'(fifo_level), 64'd0);
      idle();
      exp_req("t6.r3", 1'b0, 3'd0, 32'h0);
      chk("t6.r3.level", 64'(fifo_level), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/perf_retire_feeder.md
# perf_retire_feeder

Upstream feeder for the per-thread performance counters. Taps the integer unit's commit stream, discards annulled/trapped and per-thread-disabled instructions, and buffers the rest in a small FIFO. Issues at most one `perf_count_write_req_in` per cycle and never issues the same thread ID on two consecutive cycles, which removes the counter RAMs' read-modify-write hazard. Counts commits lost to FIFO overflow.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of two and at least 2.
- `DROP_W`, default 16: width of the drop counter.

Ports:
- `gclk`, input, `iu_clk_type`: only `gclk.clk` is used; single clock domain.
- `rst`, input, 1: reset, asynchronous, active-low.
- `commit_valid`, input, 1: an instruction commits this cycle.
- `commit_tid`, input, `NTHREADIDMSB+1`: thread ID of the commit.
- `commit_inst`, input, 32: instruction word of the commit.
- `commit_annul`, input, 1: the commit was annulled or trapped; it is not counted.
- `cfg_we`, input, 1: load the thread-enable mask.
- `cfg_mask`, input, `2**(NTHREADIDMSB+1)`: per-thread count enable; bit i enables thread i.
- `drop_clr`, input, 1: clear `drop_cnt`.
- `wreq_out`, output, `perf_count_write_req_in`: fields `valid`, `tid`, `inst`; registered.
- `drop_cnt`, output, `DROP_W`: saturating count of dropped commits.
- `fifo_level`, output, `$clog2(FIFO_DEPTH)+1`: current FIFO occupancy.

## Operation
- Accept condition: `acc = commit_valid & ~commit_annul & mask_r[commit_tid]`.
- The block holds `mask_r`. On `cfg_we` it loads `mask_r <= cfg_mask`. The new mask applies to commits from the next cycle on. Entries already in the FIFO are still issued.
- FIFO entry is `{tid, inst}`. It is a circular buffer with read and write pointers one bit wider than the index, giving an unambiguous full/empty distinction; both pointers wrap modulo `2*FIFO_DEPTH`.
- Eligibility: `elig = ~empty & ~(wreq_out.valid & (head.tid == wreq_out.tid))`.
- Issue rule, evaluated each edge:
  - If `elig`: `wreq_out <= {1, head.tid, head.inst}` and the head is popped.
  - Otherwise `wreq_out.valid <= 0`, and `tid`/`inst` hold their previous values.
- The head is never skipped. Ordering is strictly FIFO, including across threads: a blocked head stalls the whole FIFO for that one cycle.
- Push rule, when `acc` is set:
  - If not full, or full with a pop on the same edge: push.
  - Otherwise: drop the commit and set `drop_cnt <= drop_cnt + 1`, saturating at all ones.
- `drop_clr` sets `drop_cnt` to 0. If `drop_clr` and a drop occur on the same edge, the result is `drop_cnt = 1`.
- `fifo_level` is incremented by pushes and decremented by pops. A simultaneous push and pop leaves it unchanged.
- There is no backpressure from the counters: `wreq_out` is consumed every cycle it is valid.
- Reset (`rst` low, asynchronous):
  - FIFO empty, pointers 0, `fifo_level` 0.
  - `mask_r` all ones.
  - `wreq_out` = `{0, 0, 0}`.
  - `drop_cnt` 0.
- Reset asserted mid-operation discards all buffered entries; none are issued after release. The first edge after release can accept a commit.

## Timing
- Minimum latency: a commit sampled at edge E is pushed at E. It appears on `wreq_out` after edge E+1, so it is valid during the cycle following E+1. That is 2 cycles from commit to counter request.
- Throughput: one request per cycle when consecutive heads alternate thread ID.
- Same-tid pairs cost exactly one bubble cycle.
- A commit stream of one thread every cycle drains at 1 per 2 cycles. It fills the FIFO in about `2*FIFO_DEPTH` cycles and then drops 1 of every 2 commits.
- `drop_cnt`, `fifo_level` and `mask_r` update on the same edge as the push/pop that causes the change.
- Full plus simultaneous push and pop on one edge: the commit is accepted, no drop, and the level stays at `FIFO_DEPTH`.
- Empty plus push: the entry is not issued on the same edge; the earliest issue is the next edge.

## Test plan
- Reset release, then commits tid 0,1,2,3 on consecutive cycles with distinct instructions → `wreq_out` valid for 4 consecutive cycles, starting 2 cycles after the first commit, with tids 0,1,2,3 and matching `inst`; `drop_cnt` = 0.
- Tid 5 committed twice back-to-back → requests tid 5, bubble (`valid` = 0), tid 5; `fifo_level` peaks at 1.
- `FIFO_DEPTH` = 4, tid 2 committed every cycle for 20 cycles → `fifo_level` saturates at 4, `drop_cnt` > 0 and equal to 20 minus issued minus residual, issued requests never adjacent; `drop_clr` then gives 0.
- Mask write `cfg_mask` = 0 except bit 1, then commits tid 0,1,2 → only tid 1 issued. A commit with `commit_annul` = 1 on tid 1 → not issued.
- FIFO full with an eligible head, plus a commit on the same edge → accepted, `drop_cnt` unchanged, `fifo_level` stays 4.
- Assert `rst` with 3 entries buffered → `wreq_out.valid` drops immediately (asynchronously), `fifo_level` = 0, no stale issue after release, `mask_r` all ones.
